// File: rtl/note_recorder.sv
// Note recorder: samples synchronized keys/shift once per tick while
// recording and streams words to a memory slot, closing each recording
// with an all-ones terminator word unless the slot fills up first.
module note_recorder #(
  parameter int DATA_WIDTH     = 10,
  parameter int MAX_MEMORY_BIT = 3,
  parameter int STATE_WIDTH    = 3,
  parameter int TICK_CYCLES    = 1000000,
  parameter int MAX_WORDS      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rec_start,
  input  logic                      rec_stop,
  input  logic [7:0]                keys,
  input  logic [1:0]                shift_in,
  input  logic [MAX_MEMORY_BIT-1:0] slot_sel,
  input  logic                      full_flag,
  output logic                      write_en,
  output logic [MAX_MEMORY_BIT-1:0] select,
  output logic [DATA_WIDTH-1:0]     data_in,
  output logic [STATE_WIDTH-1:0]    current_state,
  output logic                      recording,
  output logic                      done,
  output logic                      overflow,
  output logic [10:0]               word_count
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [10:0]           LAST_SAMPLE_COUNT = 11'(MAX_WORDS - 1);
  localparam logic [DATA_WIDTH-1:0] TERM_WORD = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, RECORD, TERM, DONE} state_t;

  // Synchronizer vector layout: {rec_start, rec_stop, keys[7:0], shift[1:0]}
  logic [11:0] sync1_reg, sync2_reg;
  logic        start_prev_reg, stop_prev_reg;

  state_t                    state_reg, state_next;
  logic [TICK_W-1:0]         tick_reg, tick_next;
  logic [10:0]               word_count_reg, word_count_next;
  logic                      overflow_reg, overflow_next;
  logic [MAX_MEMORY_BIT-1:0] select_reg, select_next;
  logic [DATA_WIDTH-1:0]     data_reg, data_next;
  logic [DATA_WIDTH-1:0]     word_out;
  logic                      write_out;

  logic                      start_edge, stop_edge, tick_hit;
  logic [DATA_WIDTH-1:0]     sample_word;

  assign start_edge  = sync2_reg[11] & ~start_prev_reg;
  assign stop_edge   = sync2_reg[10] & ~stop_prev_reg;
  assign tick_hit    = (tick_reg == TICK_LAST);
  assign sample_word = DATA_WIDTH'(sync2_reg[9:0]);

  // Two-flop synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      start_prev_reg <= 1'b0;
      stop_prev_reg  <= 1'b0;
    end else begin
      sync1_reg      <= {rec_start, rec_stop, keys, shift_in};
      sync2_reg      <= sync1_reg;
      start_prev_reg <= sync2_reg[11];
      stop_prev_reg  <= sync2_reg[10];
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tick_reg       <= '0;
      word_count_reg <= '0;
      overflow_reg   <= 1'b0;
      select_reg     <= '0;
      data_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      tick_reg       <= tick_next;
      word_count_reg <= word_count_next;
      overflow_reg   <= overflow_next;
      select_reg     <= select_next;
      data_reg       <= data_next;
    end
  end

  // Next-state logic; full_flag outranks tick and stop while recording
  always_comb begin
    state_next      = state_reg;
    tick_next       = tick_reg;
    word_count_next = word_count_reg;
    overflow_next   = overflow_reg;
    select_next     = select_reg;
    write_out       = 1'b0;
    word_out        = data_reg;
    case (state_reg)
      IDLE: begin
        if (start_edge) begin
          select_next     = slot_sel;
          word_count_next = '0;
          overflow_next   = 1'b0;
          tick_next       = '0;
          state_next      = RECORD;
        end
      end
      RECORD: begin
        if (full_flag) begin
          overflow_next = 1'b1;
          state_next    = DONE;
        end else begin
          tick_next = tick_hit ? '0 : tick_reg + 1'b1;
          if (tick_hit) begin
            write_out       = 1'b1;
            word_out        = sample_word;
            word_count_next = word_count_reg + 11'd1;
            if (word_count_reg + 11'd1 == LAST_SAMPLE_COUNT)
              state_next = TERM;
          end
          if (stop_edge)
            state_next = TERM;
        end
      end
      TERM: begin
        if (full_flag) begin
          overflow_next = 1'b1;
        end else begin
          write_out       = 1'b1;
          word_out        = TERM_WORD;
          word_count_next = word_count_reg + 11'd1;
        end
        state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // data_in shows the word being written, otherwise the last word written
  always_comb begin
    data_next = write_out ? word_out : data_reg;
  end

  assign write_en      = write_out;
  assign data_in       = data_next;
  assign select        = select_reg;
  assign word_count    = word_count_reg;
  assign overflow      = overflow_reg;
  assign done          = (state_reg == DONE);
  assign recording     = (state_reg == RECORD) || (state_reg == TERM);
  assign current_state = recording ? STATE_WIDTH'(1) : '0;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with short ticks and tiny recordings.
module tb_note_recorder;

  logic        clk;
  logic        rst_n;
  logic        rec_start;
  logic        rec_stop;
  logic [7:0]  keys;
  logic [1:0]  shift_in;
  logic [2:0]  slot_sel;
  logic        full_flag;
  logic        write_en;
  logic [2:0]  select;
  logic [9:0]  data_in;
  logic [2:0]  current_state;
  logic        recording;
  logic        done;
  logic        overflow;
  logic [10:0] word_count;

  int n_vec;
  int n_err;

  // Write/done monitor state (only the monitor process writes these)
  int          cyc;
  int          wr_n;
  int          done_n;
  logic [9:0]  log_data [0:255];
  int          log_cyc  [0:255];

  note_recorder #(
    .DATA_WIDTH(10), .MAX_MEMORY_BIT(3), .STATE_WIDTH(3),
    .TICK_CYCLES(4), .MAX_WORDS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rec_start(rec_start), .rec_stop(rec_stop),
    .keys(keys), .shift_in(shift_in), .slot_sel(slot_sel),
    .full_flag(full_flag), .write_en(write_en), .select(select),
    .data_in(data_in), .current_state(current_state),
    .recording(recording), .done(done), .overflow(overflow),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write_en && wr_n < 256) begin
      log_data[wr_n] = data_in;
      log_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_rec(input logic [2:0] s, input logic [7:0] k, input logic [1:0] sh);
    slot_sel  = s;
    keys      = k;
    shift_in  = sh;
    rec_start = 1'b1;
    step(3);
    rec_start = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && wr_n < target; i++) step(1);
    ok = (wr_n >= target);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    for (int i = 0; i < budget && done_n < target; i++) step(1);
    ok = (done_n >= target);
  endtask

  task automatic test_reset;
    int base;
    rst_n = 1'b0;
    step(3);
    n_vec++;
    if ({write_en, select, data_in, current_state, recording, done, overflow, word_count} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we=%0b sel=%0d data=%h st=%0d rec=%0b done=%0b ovf=%0b wc=%0d, want all 0",
               write_en, select, data_in, current_state, recording, done, overflow, word_count);
    end
    rst_n = 1'b1;
    base = wr_n;
    for (int i = 0; i < 10; i++) begin
      keys = 8'(i * 37);
      step(1);
    end
    n_vec++;
    if (wr_n != base || recording !== 1'b0) begin
      n_err++;
      $display("FAIL idle_quiet: got writes=%0d rec=%0b, want writes=0 rec=0", wr_n - base, recording);
    end
    $display("test_reset done");
  endtask

  task automatic test_stop;
    int wb, db;
    bit ok;
    wb = wr_n; db = done_n;
    start_rec(3'd3, 8'h05, 2'd2);
    wait_writes(wb + 3, 60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL stop_wait_writes: got %0d writes, want 3", wr_n - wb); end
    n_vec++;
    if (recording !== 1'b1 || current_state !== 3'b001) begin
      n_err++;
      $display("FAIL stop_recording: got rec=%0b st=%0d, want rec=1 st=1", recording, current_state);
    end
    rec_stop = 1'b1;
    step(3);
    rec_stop = 1'b0;
    wait_done(db + 1, 40, ok);
    step(2);
    n_vec++;
    if (!ok || done_n - db != 1) begin n_err++; $display("FAIL stop_done: got %0d pulses, want 1", done_n - db); end
    n_vec++;
    if (wr_n - wb != 4) begin
      n_err++; $display("FAIL stop_write_count: got %0d, want 4", wr_n - wb);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (log_data[wb + i] !== 10'h016) begin
          n_err++; $display("FAIL stop_sample%0d: got %h, want 016", i, log_data[wb + i]);
        end
      end
      n_vec++;
      if (log_data[wb + 3] !== 10'h3FF) begin
        n_err++; $display("FAIL stop_terminator: got %h, want 3ff", log_data[wb + 3]);
      end
    end
    n_vec++;
    if (select !== 3'd3 || word_count !== 11'd4 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL stop_status: got sel=%0d wc=%0d ovf=%0b, want sel=3 wc=4 ovf=0", select, word_count, overflow);
    end
    n_vec++;
    if (data_in !== 10'h3FF || recording !== 1'b0 || current_state !== 3'b000) begin
      n_err++;
      $display("FAIL stop_hold: got data=%h rec=%0b st=%0d, want data=3ff rec=0 st=0", data_in, recording, current_state);
    end
    $display("test_stop done");
  endtask

  task automatic test_max_words;
    int wb, db;
    bit ok;
    wb = wr_n; db = done_n;
    start_rec(3'd1, 8'hA0, 2'd1);
    wait_done(db + 1, 120, ok);
    step(2);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL max_done: got %0d pulses, want 1", done_n - db); end
    n_vec++;
    if (wr_n - wb != 8) begin
      n_err++; $display("FAIL max_write_count: got %0d, want 8", wr_n - wb);
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (log_data[wb + i] !== 10'h281) begin
          n_err++; $display("FAIL max_sample%0d: got %h, want 281", i, log_data[wb + i]);
        end
      end
      n_vec++;
      if (log_data[wb + 7] !== 10'h3FF) begin
        n_err++; $display("FAIL max_terminator: got %h, want 3ff", log_data[wb + 7]);
      end
    end
    n_vec++;
    if (word_count !== 11'd8 || select !== 3'd1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL max_status: got wc=%0d sel=%0d ovf=%0b, want wc=8 sel=1 ovf=0", word_count, select, overflow);
    end
    $display("test_max_words done");
  endtask

  task automatic test_full;
    int wb, db;
    bit ok;
    wb = wr_n; db = done_n;
    start_rec(3'd6, 8'h3C, 2'd3);
    wait_writes(wb + 2, 60, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL full_wait_writes: got %0d, want 2", wr_n - wb); end
    step(3);
    full_flag = 1'b1;
    step(1);
    full_flag = 1'b0;
    wait_done(db + 1, 20, ok);
    step(6);
    n_vec++;
    if (!ok || done_n - db != 1) begin n_err++; $display("FAIL full_done: got %0d pulses, want 1", done_n - db); end
    n_vec++;
    if (wr_n - wb != 2) begin n_err++; $display("FAIL full_write_count: got %0d, want 2", wr_n - wb); end
    n_vec++;
    if (overflow !== 1'b1 || word_count !== 11'd2 || data_in !== 10'h0F3) begin
      n_err++;
      $display("FAIL full_status: got ovf=%0b wc=%0d data=%h, want ovf=1 wc=2 data=0f3", overflow, word_count, data_in);
    end
    $display("test_full done");
  endtask

  task automatic test_stop_on_tick;
    int wb, db;
    bit ok;
    wb = wr_n; db = done_n;
    start_rec(3'd2, 8'hFF, 2'd0);
    wait_writes(wb + 1, 60, ok);
    step(1);
    rec_stop = 1'b1;
    step(3);
    rec_stop = 1'b0;
    wait_done(db + 1, 40, ok);
    step(2);
    n_vec++;
    if (!ok || wr_n - wb != 3) begin
      n_err++; $display("FAIL tick_stop_count: got %0d writes, want 3", wr_n - wb);
    end else begin
      n_vec++;
      if (log_data[wb] !== 10'h3FC || log_data[wb + 1] !== 10'h3FC || log_data[wb + 2] !== 10'h3FF) begin
        n_err++;
        $display("FAIL tick_stop_data: got %h %h %h, want 3fc 3fc 3ff", log_data[wb], log_data[wb + 1], log_data[wb + 2]);
      end
      n_vec++;
      if (log_cyc[wb + 1] != log_cyc[wb] + 4 || log_cyc[wb + 2] != log_cyc[wb + 1] + 1) begin
        n_err++;
        $display("FAIL tick_stop_timing: got gaps %0d,%0d, want 4,1",
                 log_cyc[wb + 1] - log_cyc[wb], log_cyc[wb + 2] - log_cyc[wb + 1]);
      end
    end
    n_vec++;
    if (word_count !== 11'd3) begin n_err++; $display("FAIL tick_stop_wc: got %0d, want 3", word_count); end
    $display("test_stop_on_tick done");
  endtask

  task automatic test_reset_mid;
    int wb, db;
    bit ok;
    wb = wr_n; db = done_n;
    start_rec(3'd5, 8'h01, 2'd3);
    wait_writes(wb + 1, 60, ok);
    slot_sel  = 3'd2;
    rec_start = 1'b1;
    step(3);
    rec_start = 1'b0;
    step(2);
    n_vec++;
    if (select !== 3'd5 || recording !== 1'b1) begin
      n_err++; $display("FAIL restart_ignored: got sel=%0d rec=%0b, want sel=5 rec=1", select, recording);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({write_en, select, data_in, current_state, recording, done, overflow, word_count} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got we=%0b sel=%0d data=%h st=%0d rec=%0b done=%0b ovf=%0b wc=%0d, want all 0",
               write_en, select, data_in, current_state, recording, done, overflow, word_count);
    end
    step(3);
    rst_n = 1'b1;
    wb = wr_n; db = done_n;
    step(12);
    n_vec++;
    if (wr_n != wb || done_n != db || recording !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_term: got writes=%0d done=%0d rec=%0b, want 0 0 0", wr_n - wb, done_n - db, recording);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    cyc = 0; wr_n = 0; done_n = 0;
    rst_n = 1'b0; rec_start = 1'b0; rec_stop = 1'b0;
    keys = 8'h00; shift_in = 2'd0; slot_sel = 3'd0; full_flag = 1'b0;
    test_reset;
    test_stop;
    step(4);
    test_max_words;
    step(4);
    test_full;
    step(4);
    test_stop_on_tick;
    step(4);
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
